// File: rtl/registerfile_mp_if.sv
// registerfile_mp_if: decode/ALU-side bundle for registerfile_mp.
// The master drives addresses, write data and enables; the slave is the register file.
interface registerfile_mp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rs_addr_i;
  logic [ADDR_W-1:0] rt_addr_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              wen_i;
  logic [DATA_W-1:0] write_data_i;
  logic              oen_i;
  logic              overflow_i;
  logic              cnt_dec_i;
  logic [DATA_W-1:0] rs_val_o;
  logic [DATA_W-1:0] rt_val_o;
  logic [DATA_W-1:0] cnt_o;
  logic [DATA_W-1:0] cpsr_o;
  logic [DATA_W-1:0] ma_o;
  logic              overflow_o;
  logic              cnt_zero_o;

  modport master (
    output rs_addr_i, rt_addr_i, rd_addr_i,
    output wen_i, write_data_i,
    output oen_i, overflow_i, cnt_dec_i,
    input  rs_val_o, rt_val_o,
    input  cnt_o, cpsr_o, ma_o,
    input  overflow_o, cnt_zero_o
  );

  modport slave (
    input  rs_addr_i, rt_addr_i, rd_addr_i,
    input  wen_i, write_data_i,
    input  oen_i, overflow_i, cnt_dec_i,
    output rs_val_o, rt_val_o,
    output cnt_o, cpsr_o, ma_o,
    output overflow_o, cnt_zero_o
  );
endinterface

// File: rtl/registerfile_mp.sv
// registerfile_mp: 2R/1W register file with hardwired 0/1, saturating loop counter and overflow flag.
// Optional write-through bypass on the read ports is enabled by defining REGFILE_BYPASS_EN.
module registerfile_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int MA_REG   = 2,
  parameter int ZERO_REG = 6,
  parameter int ONE_REG  = 7,
  parameter int CNT_REG  = 9,
  parameter int CPSR_REG = 10
) (
  input  logic CLK,
  input  logic RST,
  registerfile_mp_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam bit IDX_IN_RANGE =
    (MA_REG   >= 0) && (MA_REG   < DEPTH) &&
    (ZERO_REG >= 0) && (ZERO_REG < DEPTH) &&
    (ONE_REG  >= 0) && (ONE_REG  < DEPTH) &&
    (CNT_REG  >= 0) && (CNT_REG  < DEPTH) &&
    (CPSR_REG >= 0) && (CPSR_REG < DEPTH);

  localparam bit IDX_DISTINCT =
    (MA_REG   != ZERO_REG) && (MA_REG   != ONE_REG) &&
    (MA_REG   != CNT_REG)  && (MA_REG   != CPSR_REG) &&
    (ZERO_REG != ONE_REG)  && (ZERO_REG != CNT_REG) &&
    (ZERO_REG != CPSR_REG) && (ONE_REG  != CNT_REG) &&
    (ONE_REG  != CPSR_REG) && (CNT_REG  != CPSR_REG);

  // Reject overlapping or out-of-range special indices at elaboration.
  if (!(IDX_IN_RANGE && IDX_DISTINCT)) begin : g_param_err
    $error("registerfile_mp: special register indices must be distinct and < 2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] MA_IDX   = ADDR_W'(MA_REG);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(ONE_REG);
  localparam logic [ADDR_W-1:0] CNT_IDX  = ADDR_W'(CNT_REG);
  localparam logic [ADDR_W-1:0] CPSR_IDX = ADDR_W'(CPSR_REG);

  localparam logic [DATA_W-1:0] K_ZERO = '0;
  localparam logic [DATA_W-1:0] K_ONE  = DATA_W'(1);

  logic [DATA_W-1:0] rf [DEPTH];
  logic              ovf_q;

  logic              rd_hard;
  logic              wr_eff;
  logic              cnt_wr;
  logic [DATA_W-1:0] cnt_cur;
  logic              cnt_is_zero;
  logic              dec_eff;

  // Hardwired indices swallow writes; only real storage is updated.
  assign rd_hard = (bus.rd_addr_i == ZERO_IDX) ||
                   (bus.rd_addr_i == ONE_IDX);
  assign wr_eff  = bus.wen_i && !rd_hard;
  assign cnt_wr  = wr_eff && (bus.rd_addr_i == CNT_IDX);

  assign cnt_cur     = rf[CNT_IDX];
  assign cnt_is_zero = (cnt_cur == '0);

  // A write to the counter beats a decrement; a zero counter stays at zero.
  assign dec_eff = bus.cnt_dec_i && !cnt_wr && !cnt_is_zero;

  // Storage update: reset clears everything, else write port plus counter decrement.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (wr_eff) begin
        rf[bus.rd_addr_i] <= bus.write_data_i;
      end
      if (dec_eff) begin
        rf[CNT_IDX] <= cnt_cur - K_ONE;
      end
    end
  end

  // Overflow flag loads whenever enabled, independent of the write port.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else if (bus.oen_i) begin
      ovf_q <= bus.overflow_i;
    end
  end

  logic rs_zero, rs_one, rs_byp;
  logic rt_zero, rt_one, rt_byp;

  assign rs_zero = (bus.rs_addr_i == ZERO_IDX);
  assign rs_one  = (bus.rs_addr_i == ONE_IDX);
  assign rt_zero = (bus.rt_addr_i == ZERO_IDX);
  assign rt_one  = (bus.rt_addr_i == ONE_IDX);

`ifdef REGFILE_BYPASS_EN
  // Write-through: a pending effective write is forwarded to a matching read.
  assign rs_byp = wr_eff && (bus.rs_addr_i == bus.rd_addr_i);
  assign rt_byp = wr_eff && (bus.rt_addr_i == bus.rd_addr_i);
`else
  assign rs_byp = 1'b0;
  assign rt_byp = 1'b0;
`endif

  // Read port A: constants, then bypass, then stored value.
  always_comb begin
    bus.rs_val_o = rf[bus.rs_addr_i];
    unique case (1'b1)
      rs_zero: bus.rs_val_o = K_ZERO;
      rs_one:  bus.rs_val_o = K_ONE;
      rs_byp:  bus.rs_val_o = bus.write_data_i;
      default: bus.rs_val_o = rf[bus.rs_addr_i];
    endcase
  end

  // Read port B: same selection as port A.
  always_comb begin
    bus.rt_val_o = rf[bus.rt_addr_i];
    unique case (1'b1)
      rt_zero: bus.rt_val_o = K_ZERO;
      rt_one:  bus.rt_val_o = K_ONE;
      rt_byp:  bus.rt_val_o = bus.write_data_i;
      default: bus.rt_val_o = rf[bus.rt_addr_i];
    endcase
  end

  // Taps and flags reflect stored state only, never the bypass.
  assign bus.cnt_o      = cnt_cur;
  assign bus.cpsr_o     = rf[CPSR_IDX];
  assign bus.ma_o       = rf[MA_IDX];
  assign bus.overflow_o = ovf_q;
  assign bus.cnt_zero_o = cnt_is_zero;

endmodule

// File: tb/tb_registerfile_mp.sv
// tb_registerfile_mp: directed and random checks of registerfile_mp.
// Default 8/4 instance against a reference model, plus a 16/5 width instance.
module tb_registerfile_mp;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  registerfile_mp_if #(.DATA_W(8),  .ADDR_W(4)) b8 ();
  registerfile_mp_if #(.DATA_W(16), .ADDR_W(5)) b16 ();

  registerfile_mp #(.DATA_W(8), .ADDR_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (b8)
  );

  registerfile_mp #(.DATA_W(16), .ADDR_W(5)) dut16 (
    .CLK (CLK),
    .RST (RST),
    .bus (b16)
  );

  int n_asrt = 0;
  int n_fail = 0;

  logic [7:0] m [16];
  logic       mf;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    mf = 1'b0;
  endtask

  // Expected value on a read port given the inputs currently driven.
  function automatic logic [7:0] exp_rd(input logic [3:0] a);
    if (a == 4'd6) return 8'h00;
    if (a == 4'd7) return 8'h01;
`ifdef REGFILE_BYPASS_EN
    if (b8.wen_i && b8.rd_addr_i == a) return b8.write_data_i;
`endif
    return m[a];
  endfunction

  // Apply the register file rules to the model, then cross the edge.
  task automatic step();
    bit eff;
    eff = b8.wen_i && b8.rd_addr_i != 4'd6 && b8.rd_addr_i != 4'd7;
    if (b8.oen_i) mf = b8.overflow_i;
    if (eff) m[b8.rd_addr_i] = b8.write_data_i;
    if (b8.cnt_dec_i && !(eff && b8.rd_addr_i == 4'd9) && m[9] != 0)
      m[9] = m[9] - 8'd1;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    b8.wen_i = 1'b0;
    b8.oen_i = 1'b0;
    b8.overflow_i = 1'b0;
    b8.cnt_dec_i = 1'b0;
    b8.write_data_i = 8'h00;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    b8.rd_addr_i = a;
    b8.write_data_i = d;
    b8.wen_i = 1'b1;
    step();
    idle();
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a,
                        input logic [7:0] exp);
    b8.rs_addr_i = a;
    b8.rt_addr_i = a;
    #1;
    chk({tag, "_rs"}, b8.rs_val_o, exp);
    chk({tag, "_rt"}, b8.rt_val_o, exp);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_cnt"},  b8.cnt_o, m[9]);
    chk({tag, "_cpsr"}, b8.cpsr_o, m[10]);
    chk({tag, "_ma"},   b8.ma_o, m[2]);
    chk({tag, "_ovf"},  b8.overflow_o, mf);
    chk({tag, "_cz"},   b8.cnt_zero_o, (m[9] == 8'h00));
  endtask

  initial begin
    b8.rs_addr_i = '0;
    b8.rt_addr_i = '0;
    b8.rd_addr_i = '0;
    idle();
    b16.rs_addr_i = '0;
    b16.rt_addr_i = '0;
    b16.rd_addr_i = '0;
    b16.wen_i = 1'b0;
    b16.write_data_i = '0;
    b16.oen_i = 1'b0;
    b16.overflow_i = 1'b0;
    b16.cnt_dec_i = 1'b0;
    model_reset();

    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("rst_cnt",  b8.cnt_o, 8'h00);
    chk("rst_cpsr", b8.cpsr_o, 8'h00);
    chk("rst_ma",   b8.ma_o, 8'h00);
    chk("rst_ovf",  b8.overflow_o, 1'b0);
    chk("rst_cz",   b8.cnt_zero_o, 1'b1);
    rd_chk("rst_r6", 4'd6, 8'h00);
    rd_chk("rst_r7", 4'd7, 8'h01);

    b8.oen_i = 1'b1;
    b8.overflow_i = 1'b1;
    wr(4'd3, 8'hAA);
    rd_chk("wr_r3", 4'd3, 8'hAA);
    chk("wr_ovf", b8.overflow_o, 1'b1);

    RST = 1'b1;
    model_reset();
    #1;
    rd_chk("midrst_r3", 4'd3, 8'h00);
    chk("midrst_cz",  b8.cnt_zero_o, 1'b1);
    chk("midrst_ovf", b8.overflow_o, 1'b0);
    b8.rd_addr_i = 4'd5;
    b8.write_data_i = 8'h77;
    b8.wen_i = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle();
    rd_chk("rstwr_r5", 4'd5, 8'h00);

    wr(4'd5, 8'h5A);
    rd_chk("post_rst_r5", 4'd5, 8'h5A);

    b8.oen_i = 1'b1;
    b8.overflow_i = 1'b1;
    wr(4'd6, 8'hFF);
    rd_chk("hw_r6", 4'd6, 8'h00);
    chk("hw_ovf6", b8.overflow_o, 1'b1);
    b8.oen_i = 1'b1;
    b8.overflow_i = 1'b0;
    wr(4'd7, 8'hFF);
    rd_chk("hw_r7", 4'd7, 8'h01);
    chk("hw_ovf7", b8.overflow_o, 1'b0);
    b8.oen_i = 1'b1;
    b8.overflow_i = 1'b1;
    wr(4'd7, 8'hFF);
    chk("hw_ovf7b", b8.overflow_o, 1'b1);
    rd_chk("hw_r7b", 4'd7, 8'h01);

    wr(4'd9, 8'h02);
    chk("cnt_ld", b8.cnt_o, 8'h02);
    chk("cnt_ld_cz", b8.cnt_zero_o, 1'b0);
    b8.cnt_dec_i = 1'b1;
    step();
    chk("cnt_d1", b8.cnt_o, 8'h01);
    chk("cnt_d1_cz", b8.cnt_zero_o, 1'b0);
    step();
    chk("cnt_d2", b8.cnt_o, 8'h00);
    chk("cnt_d2_cz", b8.cnt_zero_o, 1'b1);
    step();
    chk("cnt_d3", b8.cnt_o, 8'h00);
    chk("cnt_d3_cz", b8.cnt_zero_o, 1'b1);
    idle();

    wr(4'd9, 8'h05);
    chk("col_pre", b8.cnt_o, 8'h05);
    b8.cnt_dec_i = 1'b1;
    wr(4'd9, 8'h10);
    chk("col_cnt", b8.cnt_o, 8'h10);
    b8.cnt_dec_i = 1'b1;
    step();
    idle();
    chk("col_dec", b8.cnt_o, 8'h0F);

    wr(4'd2, 8'hC3);
    wr(4'd10, 8'h81);
    chk("tap_ma", b8.ma_o, 8'hC3);
    chk("tap_cpsr", b8.cpsr_o, 8'h81);

    wr(4'd4, 8'h11);
    b8.rs_addr_i = 4'd4;
    b8.rt_addr_i = 4'd9;
    b8.rd_addr_i = 4'd4;
    b8.wen_i = 1'b1;
    b8.write_data_i = 8'h3C;
    b8.cnt_dec_i = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_pre", b8.rs_val_o, 8'h3C);
`else
    chk("byp_pre", b8.rs_val_o, 8'h11);
`endif
    chk("byp_cnt_rd", b8.rt_val_o, 8'h0F);
    chk("byp_cnt_tap", b8.cnt_o, 8'h0F);
    step();
    idle();
    chk("byp_post", b8.rs_val_o, 8'h3C);
    chk("byp_cnt_post", b8.cnt_o, 8'h0E);

    for (int i = 0; i < 200; i++) begin
      b8.rs_addr_i = 4'($urandom_range(0, 15));
      b8.rt_addr_i = ($urandom_range(0, 3) == 0) ? 4'd9
                     : 4'($urandom_range(0, 15));
      b8.rd_addr_i = ($urandom_range(0, 3) == 0) ? b8.rs_addr_i
                     : 4'($urandom_range(0, 15));
      b8.wen_i = 1'($urandom_range(0, 1));
      b8.write_data_i = ($urandom_range(0, 5) == 0) ? 8'h01
                        : 8'($urandom);
      b8.oen_i = 1'($urandom_range(0, 1));
      b8.overflow_i = 1'($urandom_range(0, 1));
      b8.cnt_dec_i = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_rs", b8.rs_val_o, exp_rd(b8.rs_addr_i));
      chk("rnd_rt", b8.rt_val_o, exp_rd(b8.rt_addr_i));
      step();
      chk_state("rnd");
    end
    idle();

    b16.rd_addr_i = 5'd31;
    b16.write_data_i = 16'hBEEF;
    b16.wen_i = 1'b1;
    @(posedge CLK);
    #1;
    b16.wen_i = 1'b0;
    b16.rs_addr_i = 5'd31;
    b16.rt_addr_i = 5'd31;
    #1;
    chk("w16_rs", b16.rs_val_o, 16'hBEEF);
    chk("w16_rt", b16.rt_val_o, 16'hBEEF);
    b16.rs_addr_i = 5'd7;
    b16.rt_addr_i = 5'd6;
    #1;
    chk("w16_r7", b16.rs_val_o, 16'h0001);
    chk("w16_r6", b16.rt_val_o, 16'h0000);
    chk("w16_cz", b16.cnt_zero_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
